fetch_prefetch_buf: RTL

- Instruction prefetch/line buffer between the 64-bit instruction SRAM port and the RV16/RV32 aligner/expander.
- Issues line-aligned fetch requests and queues returned 64-bit lines.
- Tracks the current PC at halfword granularity and presents a raw 32-bit instruction window, including windows that straddle two lines. A downstream stall holds the window.
- Removes any need for the aligner to keep a "previous upper halfword" register.

---
 rtl/fetch_prefetch_buf_pkg.sv | 18 +
 rtl/fetch_line_fifo.sv | 55 +++++
 rtl/fetch_prefetch_buf.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer and its line FIFO.
package fetch_prefetch_buf_pkg;

  localparam int unsigned LINE_BYTES   = 8;
  localparam int unsigned HW_PER_LINE  = 4;
  localparam int unsigned LINE_W       = LINE_BYTES * 8;
  localparam logic [1:0]  RV32_OPC_LOW = 2'b11;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // A fetched line viewed as halfwords; element k is bits [16k+15:16k].
  typedef logic [HW_PER_LINE-1:0][15:0] line_hw_t;

  // Compressed instructions are those whose low opcode bits are not 2'b11.
  function automatic logic is_rv16(input logic [15:0] hw);
    return hw[1:0] != RV32_OPC_LOW;
  endfunction

endpackage

// File: rtl/fetch_line_fifo.sv
// Small FIFO of fetched lines with a two-entry peek (head and head+1).
module fetch_line_fifo
  import fetch_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [LINE_W-1:0] push_data,
  input  logic              pop,
  output logic [LINE_W-1:0] head,
  output logic [LINE_W-1:0] head_next,
  output logic [CW-1:0]     count
);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Line storage write port.
  // NOTE: the storage array has no reset; validity comes only from count, so
  // resetting the data would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear beats push and pop.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch/line buffer: issues line-aligned SRAM reads, queues
// returned lines and presents a 32-bit window at the current halfword PC.
module fetch_prefetch_buf
  import fetch_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [63:0] rsp_data_i,
  output logic        out_valid_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        out_isrv16_o,
  input  logic        out_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [1:0]    hw_off;
  logic [28:0]   fetch_line;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW-1:0]     entries;
  logic [LINE_W-1:0] head;
  logic [LINE_W-1:0] head_next;
  line_hw_t          head_hw;
  line_hw_t          next_hw;
  logic [15:0]       hw_lo;
  logic [15:0]       hw_hi;
  logic              isrv16;
  logic              have_one;
  logic              have_two;
  logic              fire;
  logic [2:0]        hw_sum;
  logic              pop;
  logic [CW:0]       in_flight;
  logic              accept;
  logic              rsp_drop;
  logic              push;

  fetch_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .push      (push),
    .push_data (rsp_data_i),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (entries)
  );

  // Instruction window: low half at hw_off, high half either the next
  // halfword of the head line or slot 0 of the following line.
  assign head_hw = head;
  assign next_hw = head_next;
  assign hw_lo   = head_hw[hw_off];
  assign hw_hi   = (hw_off == 2'd3) ? next_hw[0] : head_hw[hw_off + 2'd1];
  assign isrv16  = is_rv16(hw_lo);

  // At least one / two halfwords available from hw_off onwards.
  assign have_one = (entries != '0);
  assign have_two = (entries >= CW'(2)) || (have_one && hw_off != 2'd3);

  assign out_valid_o  = rst_n && ((have_one && isrv16) || have_two);
  assign out_pc_o     = pc;
  assign out_instr_o  = {hw_hi, hw_lo};
  assign out_isrv16_o = isrv16;

  // Consume: advance by one or two halfwords; a carry out retires the head.
  assign fire   = out_valid_o && out_ready_i && !flush_i;
  assign hw_sum = {1'b0, hw_off} + (isrv16 ? 3'd1 : 3'd2);
  assign pop    = fire && hw_sum[2];

  // Requests only go out when a FIFO slot is reserved for the reply, so
  // responses can always be accepted.
  assign in_flight   = {1'b0, entries} + {1'b0, outstanding};
  assign req_valid_o = rst_n && !flush_i && (in_flight < (CW + 1)'(DEPTH));
  assign req_addr_o  = {fetch_line, 3'b000};
  assign accept      = req_valid_o && req_ready_i;

  // Replies belonging to a redirected stream are discarded, not queued.
  assign rsp_drop = rsp_valid_i && (drop != '0);
  assign push     = rsp_valid_i && !rsp_drop && !flush_i;

  // PC, offset, fetch pointer and credit tracking; flush overrides the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      hw_off      <= RESET_PC[2:1];
      fetch_line  <= RESET_PC[31:3];
      outstanding <= '0;
      drop        <= '0;
    end else if (flush_i) begin
      pc          <= flush_pc_i;
      hw_off      <= flush_pc_i[2:1];
      fetch_line  <= flush_pc_i[31:3];
      outstanding <= outstanding - CW'(rsp_valid_i);
      drop        <= outstanding - CW'(rsp_valid_i);
    end else begin
      if (fire) begin
        pc     <= pc + (isrv16 ? 32'd2 : 32'd4);
        hw_off <= hw_sum[1:0];
      end
      if (accept) begin
        fetch_line <= fetch_line + 29'd1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(rsp_valid_i);
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
    end
  end

endmodule
